id_stage: RTL and testbench
===========================

# id_stage

Registered, parametrised decode stage that supersedes the combinational decoder. It decodes the 64-bit instruction word, reads the register file and selects operands with EX/MEM forwarding. It detects load-use hazards and stalls for them, and drives the ID/EX pipeline register through a valid/ready handshake with flush support. It sits between fetch (`inst_valid_i`/`inst_ready_o`) and the ALU (`valid_o`/`ex_ready_i`).

## Interface
- `DW`, 32: data/register width; must be ≥ 32. Immediates zero-extend to `DW`.
- `PCW`, 32: PC width.
- `SCW`, 16: width of the stall counter.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pc_i` in `PCW`: PC of the presented instruction.
- `inst_i` in 64: instruction. Fields: mem[63:60], op[59:52], wd[51:47], rs1[46:42], rs2[41:37].
- `inst_valid_i` in 1 / `inst_ready_o` out 1: input handshake.
- `reg1_read_o`, `reg2_read_o` out 1: register file read enables (combinational).
- `reg1_addr_o`, `reg2_addr_o` out 5: register file read addresses (combinational).
- `reg1_data_i`, `reg2_data_i` in `DW`: register file read data.
- `ex_wreg_i` in 1, `ex_wd_i` in 5, `ex_wdata_i` in `DW`, `ex_is_load_i` in 1: EX-stage result of the instruction currently held in `valid_o`.
- `mem_wreg_i` in 1, `mem_wd_i` in 5, `mem_wdata_i` in `DW`: MEM-stage result.
- `flush_i` in 1: kill the in-flight decode.
- `ex_ready_i` in 1: EX accepts the output register this cycle.
- `valid_o` out 1: output register holds an instruction.
- `aluop_o` out 8, `alusel_o` out 3, `reg1_o`/`reg2_o` out `DW`, `wd_o` out 5, `wreg_o` out 1, `pc_o` out `PCW`: registered decode results.
- `illegal_o` out 1: the held instruction did not decode.
- `stall_cnt_o` out `SCW`: saturating count of hazard stall cycles.

## Operation
- **Decode table (codes from defines.v).**
  - MEM_SREG: reg1 is read, reg2 is not, `wreg` = 1, imm = `inst_i[41:10]`.
    - OR/AND/XOR → LOGIC; SHL/SHR → SHIFT.
    - NOT: reg1 is not read; imm = `inst_i[46:16]`.
    - SAR: imm = `inst_i[41:37]`.
  - MEM_DREG: reg1 and reg2 are read, `wreg` = 1. Same op set; NOT does not read reg2.
  - Any other mem/op value: aluop EXE_NOP_OP, alusel EXE_RES_NOP, `wreg` = 0, `illegal` = 1. The instruction is still accepted and passed down.
- **Operand selection** (per operand, in priority order):
  1. Read disabled → imm.
  2. Address 0 → 0.
  3. `ex_wreg_i` && `ex_wd_i` == addr → `ex_wdata_i`.
  4. `mem_wreg_i` && `mem_wd_i` == addr → `mem_wdata_i`.
  5. Otherwise the register file data.
- **Hazard.** Asserted when `valid_o` && `ex_is_load_i` && `ex_wreg_i` && `ex_wd_i` ≠ 0 && `ex_wd_i` equals an operand address that is actually read.
- **Advance.** `adv` = !`valid_o` || `ex_ready_i`.
- `inst_ready_o` = `flush_i` || (`adv` && !hazard).
- **Register update, in priority order:**
  1. `rst`: all outputs cleared.
  2. `flush_i`: `valid_o` ← 0. A presented instruction is consumed and discarded.
  3. `adv` && accept (`inst_valid_i` && `inst_ready_o`): load the decode results, `valid_o` ← 1.
  4. `adv` && no accept: bubble, `valid_o` ← 0. The other fields hold.
  5. !`adv`: hold everything.
- **Stall counter.** Increments on each cycle with `inst_valid_i` && hazard && !`flush_i`. Saturates at all-ones.

## Timing
- Latency is 1 cycle, input accept to `valid_o`. Throughput is 1 instruction per cycle with no hazards.
- A load-use hazard inserts exactly 1 bubble. On the next cycle the load result arrives on `mem_*` and is forwarded.
- `reg*_read_o`, `reg*_addr_o`, `inst_ready_o` and hazard are combinational from the current inputs. Everything else is registered.
- Reset values:
  - `valid_o`, `wreg_o`, `illegal_o`: 0.
  - `aluop_o`: EXE_NOP_OP; `alusel_o`: EXE_RES_NOP.
  - `reg1_o`, `reg2_o`, `wd_o`, `pc_o`, `stall_cnt_o`: 0.
- While `rst` is high, `inst_ready_o` = 0.
- A reset mid-stall clears the counter and drops the held instruction.
- `flush_i` together with a hazard: flush wins and the counter does not increment.

## Configuration
- `ID_FWD_EN` defined:
  - Forwarding as described above.
  - Hazard is load-use only.
- `ID_FWD_EN` undefined:
  - No forwarding mux; operands come from imm, 0 or the register file only.
  - Hazard is any read operand (address ≠ 0) matching `ex_wd_i` with `ex_wreg_i`, or `mem_wd_i` with `mem_wreg_i`.
  - The stage stalls until both stages clear.

## Test plan
- **Reset + immediate.** Hold `rst` 2 cycles, then present SREG OR r3←r1 \| imm 0x1234 with r1 = 0x00FF0000, `ex_ready_i` = 1 → next cycle `valid_o` = 1, `reg1_o` = 0x00FF0000, `reg2_o` = 0x00001234, `wd_o` = 3, `wreg_o` = 1.
- **EX forwarding.** `ex_wreg_i` = 1, `ex_wd_i` = 1, `ex_wdata_i` = 0xAAAA5555, and `mem_*` also targeting r1 with 0x11111111 → `reg1_o` = 0xAAAA5555 (EX beats MEM). The same case with address 0 gives `reg1_o` = 0.
- **Load-use.** `ex_is_load_i` = 1, `ex_wd_i` = 2, DREG AND reading r2 → `inst_ready_o` = 0 for 1 cycle, one bubble (`valid_o` = 0), `stall_cnt_o` = 1. Next cycle the MEM value is forwarded.
- **Backpressure + flush.** `ex_ready_i` = 0 for 3 cycles → outputs held stable and `inst_ready_o` = 0. Then `flush_i` = 1 → `valid_o` = 0 the next cycle and the presented instruction is discarded.
- **Illegal.** mem = 4'hF → accepted, `illegal_o` = 1, `wreg_o` = 0, aluop EXE_NOP_OP.
- **Without `ID_FWD_EN`.** `mem_wreg_i` = 1, `mem_wd_i` = 4, instruction reads r4 → stall until `mem_wreg_i` drops, then `reg1_o` = register file data.

Source files
------------

// File: rtl/id_stage.sv
// Registered decode stage: decode, operand select with EX/MEM forwarding, load-use stall,
// ID/EX valid/ready register. Define ID_FWD_EN for forwarding; otherwise stall on any RAW.
module id_stage #(
  parameter int unsigned DW  = 32,
  parameter int unsigned PCW = 32,
  parameter int unsigned SCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [PCW-1:0] pc_i,
  input  logic [63:0]    inst_i,
  input  logic           inst_valid_i,
  output logic           inst_ready_o,
  output logic           reg1_read_o,
  output logic           reg2_read_o,
  output logic [4:0]     reg1_addr_o,
  output logic [4:0]     reg2_addr_o,
  input  logic [DW-1:0]  reg1_data_i,
  input  logic [DW-1:0]  reg2_data_i,
  input  logic           ex_wreg_i,
  input  logic [4:0]     ex_wd_i,
  input  logic [DW-1:0]  ex_wdata_i,
  input  logic           ex_is_load_i,
  input  logic           mem_wreg_i,
  input  logic [4:0]     mem_wd_i,
  input  logic [DW-1:0]  mem_wdata_i,
  input  logic           flush_i,
  input  logic           ex_ready_i,
  output logic           valid_o,
  output logic [7:0]     aluop_o,
  output logic [2:0]     alusel_o,
  output logic [DW-1:0]  reg1_o,
  output logic [DW-1:0]  reg2_o,
  output logic [4:0]     wd_o,
  output logic           wreg_o,
  output logic [PCW-1:0] pc_o,
  output logic           illegal_o,
  output logic [SCW-1:0] stall_cnt_o
);

  localparam logic [3:0] MemSreg     = 4'h1;
  localparam logic [3:0] MemDreg     = 4'h2;
  localparam logic [7:0] ExeNopOp    = 8'h00;
  localparam logic [7:0] ExeShrOp    = 8'h02;
  localparam logic [7:0] ExeSarOp    = 8'h03;
  localparam logic [7:0] ExeAndOp    = 8'h24;
  localparam logic [7:0] ExeOrOp     = 8'h25;
  localparam logic [7:0] ExeXorOp    = 8'h26;
  localparam logic [7:0] ExeNotOp    = 8'h27;
  localparam logic [7:0] ExeShlOp    = 8'h7c;
  localparam logic [2:0] ExeResNop   = 3'b000;
  localparam logic [2:0] ExeResLogic = 3'b001;
  localparam logic [2:0] ExeResShift = 3'b010;

  logic [3:0] mem_f;
  logic [7:0] op_f;
  logic [4:0] wd_f, rs1, rs2;
  logic       is_dreg;

  assign mem_f   = inst_i[63:60];
  assign op_f    = inst_i[59:52];
  assign wd_f    = inst_i[51:47];
  assign rs1     = inst_i[46:42];
  assign rs2     = inst_i[41:37];
  assign is_dreg = (mem_f == MemDreg);

  logic [7:0]    dec_aluop;
  logic [2:0]    dec_alusel;
  logic          dec_wreg, dec_illegal, rd1_en, rd2_en;
  logic [DW-1:0] imm;

  always_comb begin
    dec_aluop   = ExeNopOp;
    dec_alusel  = ExeResNop;
    dec_wreg    = 1'b0;
    dec_illegal = 1'b1;
    rd1_en      = 1'b0;
    rd2_en      = 1'b0;
    imm         = '0;
    if (mem_f == MemSreg || mem_f == MemDreg) begin
      case (op_f)
        ExeOrOp, ExeAndOp, ExeXorOp, ExeNotOp: begin
          dec_alusel  = ExeResLogic;
          dec_illegal = 1'b0;
        end
        ExeShlOp, ExeShrOp, ExeSarOp: begin
          dec_alusel  = ExeResShift;
          dec_illegal = 1'b0;
        end
        default: ;
      endcase
      if (!dec_illegal) begin
        dec_aluop  = op_f;
        dec_wreg   = 1'b1;
        rd1_en     = 1'b1;
        rd2_en     = is_dreg;
        imm[31:0]  = inst_i[41:10];
        if (op_f == ExeNotOp) begin
          if (is_dreg) begin
            rd2_en = 1'b0;
          end else begin
            rd1_en     = 1'b0;
            imm        = '0;
            imm[30:0]  = inst_i[46:16];
          end
        end else if (op_f == ExeSarOp) begin
          imm       = '0;
          imm[4:0]  = inst_i[41:37];
        end
      end
    end
  end

  logic [DW-1:0] op1, op2;

  always_comb begin
    op1 = reg1_data_i;
    if (!rd1_en) op1 = imm;
    else if (rs1 == 5'd0) op1 = '0;
`ifdef ID_FWD_EN
    else if (ex_wreg_i && ex_wd_i == rs1) op1 = ex_wdata_i;
    else if (mem_wreg_i && mem_wd_i == rs1) op1 = mem_wdata_i;
`endif
    op2 = reg2_data_i;
    if (!rd2_en) op2 = imm;
    else if (rs2 == 5'd0) op2 = '0;
`ifdef ID_FWD_EN
    else if (ex_wreg_i && ex_wd_i == rs2) op2 = ex_wdata_i;
    else if (mem_wreg_i && mem_wd_i == rs2) op2 = mem_wdata_i;
`endif
  end

  logic           valid_q, valid_d;
  logic [7:0]     aluop_q, aluop_d;
  logic [2:0]     alusel_q, alusel_d;
  logic [DW-1:0]  reg1_q, reg1_d, reg2_q, reg2_d;
  logic [4:0]     wd_q, wd_d;
  logic           wreg_q, wreg_d, illegal_q, illegal_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
  logic           hazard, adv, accept;

`ifdef ID_FWD_EN
  assign hazard = valid_q && ex_is_load_i && ex_wreg_i && (ex_wd_i != 5'd0) &&
                  ((rd1_en && ex_wd_i == rs1) || (rd2_en && ex_wd_i == rs2));
`else
  // Without forwarding, any pending write to a read operand must retire first.
  assign hazard =
      (rd1_en && rs1 != 5'd0 && ((ex_wreg_i && ex_wd_i == rs1) || (mem_wreg_i && mem_wd_i == rs1))) ||
      (rd2_en && rs2 != 5'd0 && ((ex_wreg_i && ex_wd_i == rs2) || (mem_wreg_i && mem_wd_i == rs2)));
  logic unused_fwd;
  assign unused_fwd = ^{ex_is_load_i, ex_wdata_i, mem_wdata_i};
`endif

  logic unused_inst;
  assign unused_inst = ^inst_i[9:0];

  assign adv          = !valid_q || ex_ready_i;
  assign inst_ready_o = !rst && (flush_i || (adv && !hazard));
  assign accept       = inst_valid_i && inst_ready_o;

  always_comb begin
    valid_d     = valid_q;
    aluop_d     = aluop_q;
    alusel_d    = alusel_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    pc_d        = pc_q;
    illegal_d   = illegal_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (adv) begin
      valid_d = accept;
      if (accept) begin
        aluop_d   = dec_aluop;
        alusel_d  = dec_alusel;
        reg1_d    = op1;
        reg2_d    = op2;
        wd_d      = wd_f;
        wreg_d    = dec_wreg;
        pc_d      = pc_i;
        illegal_d = dec_illegal;
      end
    end
    if (inst_valid_i && hazard && !flush_i && stall_cnt_q != {SCW{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + SCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      aluop_q     <= ExeNopOp;
      alusel_q    <= ExeResNop;
      reg1_q      <= '0;
      reg2_q      <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      pc_q        <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      aluop_q     <= aluop_d;
      alusel_q    <= alusel_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      pc_q        <= pc_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign reg1_read_o = rd1_en;
  assign reg2_read_o = rd2_en;
  assign reg1_addr_o = rs1;
  assign reg2_addr_o = rs2;
  assign valid_o     = valid_q;
  assign aluop_o     = aluop_q;
  assign alusel_o    = alusel_q;
  assign reg1_o      = reg1_q;
  assign reg2_o      = reg2_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign pc_o        = pc_q;
  assign illegal_o   = illegal_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vector table plus backpressure, flush, hazard and reset
// sequences. Expectations follow the ID_FWD_EN setting of the build.
module tb_id_stage;
  localparam int DW  = 32;
  localparam int PCW = 32;
  localparam int SCW = 16;

  localparam logic [7:0] OpShr = 8'h02, OpSar = 8'h03, OpAnd = 8'h24, OpOr = 8'h25;
  localparam logic [7:0] OpXor = 8'h26, OpNot = 8'h27, OpShl = 8'h7c;
  localparam logic [2:0] SelNop = 3'b000, SelLogic = 3'b001, SelShift = 3'b010;

  logic           clk, rst;
  logic [PCW-1:0] pc_i;
  logic [63:0]    inst_i;
  logic           inst_valid_i, inst_ready_o;
  logic           reg1_read_o, reg2_read_o;
  logic [4:0]     reg1_addr_o, reg2_addr_o;
  logic [DW-1:0]  reg1_data_i, reg2_data_i;
  logic           ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]     ex_wd_i, mem_wd_i;
  logic [DW-1:0]  ex_wdata_i, mem_wdata_i;
  logic           flush_i, ex_ready_i, valid_o, wreg_o, illegal_o;
  logic [7:0]     aluop_o;
  logic [2:0]     alusel_o;
  logic [DW-1:0]  reg1_o, reg2_o;
  logic [4:0]     wd_o;
  logic [PCW-1:0] pc_o;
  logic [SCW-1:0] stall_cnt_o;

  id_stage #(.DW(DW), .PCW(PCW), .SCW(SCW)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .inst_ready_o(inst_ready_o), .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o), .reg1_data_i(reg1_data_i),
    .reg2_data_i(reg2_data_i), .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i),
    .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i), .mem_wreg_i(mem_wreg_i),
    .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i), .flush_i(flush_i),
    .ex_ready_i(ex_ready_i), .valid_o(valid_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o),
    .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [63:0] inst;
    logic [31:0] pc, rd1, rd2, e_r1, e_r2;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [7:0]  e_aluop;
    logic [2:0]  e_alusel;
    logic        e_ill, e_rd1, e_rd2;
  } vec_t;

  localparam int NV = 10;
  vec_t        vecs[NV];
  int          n_chk = 0, n_fail = 0;
  logic [15:0] exp_cnt;
  logic [63:0] hz_inst;

  function automatic logic [63:0] sreg(input logic [7:0] op, input logic [4:0] wd,
                                       input logic [4:0] r1, input logic [31:0] im);
    return {4'h1, op, wd, r1, im, 10'h0};
  endfunction

  function automatic logic [63:0] dreg(input logic [7:0] op, input logic [4:0] wd,
                                       input logic [4:0] r1, input logic [4:0] r2);
    return {4'h2, op, wd, r1, r2, 37'h0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] ins, input logic [31:0] pc, input logic [31:0] d1,
                       input logic [31:0] d2);
    inst_i = ins; pc_i = pc; reg1_data_i = d1; reg2_data_i = d2; inst_valid_i = 1'b1;
  endtask

  task automatic clear_fwd();
    ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
  endtask

  task automatic set_hazard();
`ifdef ID_FWD_EN
    ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 5'd4;
`else
    mem_wreg_i = 1; mem_wd_i = 5'd4;
`endif
  endtask

  task automatic accept_v0();
    clear_fwd();
    drive(vecs[0].inst, 32'h300, vecs[0].rd1, vecs[0].rd2);
    #1;
    step();
  endtask

  initial begin
    vecs[0] = '{sreg(OpOr, 3, 1, 32'h1234), 32'h100, 32'h00FF0000, 32'h0,
                32'h00FF0000, 32'h1234, 5'd3, 1, OpOr, SelLogic, 0, 1, 0};
    vecs[1] = '{sreg(OpNot, 4, 5'h1F, 32'h0), 32'h104, 32'hDEADBEEF, 32'h0,
                32'h7C000000, 32'h7C000000, 5'd4, 1, OpNot, SelLogic, 0, 0, 0};
    vecs[2] = '{sreg(OpSar, 7, 2, 32'hB0000000), 32'h108, 32'h12345678, 32'h0,
                32'h12345678, 32'h16, 5'd7, 1, OpSar, SelShift, 0, 1, 0};
    vecs[3] = '{sreg(OpShl, 8, 0, 32'h5), 32'h10C, 32'hFFFFFFFF, 32'h0,
                32'h0, 32'h5, 5'd8, 1, OpShl, SelShift, 0, 1, 0};
    vecs[4] = '{dreg(OpXor, 9, 6, 7), 32'h110, 32'h0F0F0F0F, 32'hF0F0F0F0,
                32'h0F0F0F0F, 32'hF0F0F0F0, 5'd9, 1, OpXor, SelLogic, 0, 1, 1};
    vecs[5] = '{dreg(OpNot, 10, 6, 7), 32'h114, 32'h11223344, 32'h55667788,
                32'h11223344, 32'h38000000, 5'd10, 1, OpNot, SelLogic, 0, 1, 0};
    vecs[6] = '{dreg(OpShr, 11, 3, 0), 32'h118, 32'hA5A5A5A5, 32'h0000FFFF,
                32'hA5A5A5A5, 32'h0, 5'd11, 1, OpShr, SelShift, 0, 1, 1};
    vecs[7] = '{dreg(OpAnd, 12, 1, 2), 32'h11C, 32'h1, 32'h3,
                32'h1, 32'h3, 5'd12, 1, OpAnd, SelLogic, 0, 1, 1};
    vecs[8] = '{{4'hF, OpOr, 5'd10, 5'd1, 5'd2, 37'h0}, 32'h120, 32'h99, 32'h98,
                32'h0, 32'h0, 5'd10, 0, 8'h00, SelNop, 1, 0, 0};
    vecs[9] = '{{4'h1, 8'h99, 5'd13, 5'd1, 32'hFFFF, 10'h0}, 32'h124, 32'h99, 32'h98,
                32'h0, 32'h0, 5'd13, 0, 8'h00, SelNop, 1, 0, 0};
    hz_inst = sreg(OpOr, 3, 4, 32'h10);
    exp_cnt = 0;

    // Reset with a valid instruction presented
    rst = 1; flush_i = 0; ex_ready_i = 1; clear_fwd();
    drive(vecs[0].inst, 32'h100, 32'h1, 32'h2);
    #1;
    chk("ready_in_reset", inst_ready_o, 0);
    step(); step();
    chk("rst valid", valid_o, 0);
    chk("rst wreg", wreg_o, 0);
    chk("rst illegal", illegal_o, 0);
    chk("rst aluop", aluop_o, 8'h00);
    chk("rst alusel", alusel_o, SelNop);
    chk("rst reg1", reg1_o, 0);
    chk("rst reg2", reg2_o, 0);
    chk("rst wd", wd_o, 0);
    chk("rst pc", pc_o, 0);
    chk("rst stall_cnt", stall_cnt_o, 0);
    rst = 0;

    // Decode table, one instruction per cycle
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].inst, vecs[i].pc, vecs[i].rd1, vecs[i].rd2);
      #1;
      chk($sformatf("v%0d ready", i), inst_ready_o, 1);
      chk($sformatf("v%0d reg1_read", i), reg1_read_o, vecs[i].e_rd1);
      chk($sformatf("v%0d reg2_read", i), reg2_read_o, vecs[i].e_rd2);
      chk($sformatf("v%0d reg1_addr", i), reg1_addr_o, vecs[i].inst[46:42]);
      step();
      chk($sformatf("v%0d valid", i), valid_o, 1);
      chk($sformatf("v%0d reg1", i), reg1_o, vecs[i].e_r1);
      chk($sformatf("v%0d reg2", i), reg2_o, vecs[i].e_r2);
      chk($sformatf("v%0d wd", i), wd_o, vecs[i].e_wd);
      chk($sformatf("v%0d wreg", i), wreg_o, vecs[i].e_wreg);
      chk($sformatf("v%0d aluop", i), aluop_o, vecs[i].e_aluop);
      chk($sformatf("v%0d alusel", i), alusel_o, vecs[i].e_alusel);
      chk($sformatf("v%0d illegal", i), illegal_o, vecs[i].e_ill);
      chk($sformatf("v%0d pc", i), pc_o, vecs[i].pc);
    end

    // Backpressure holds vecs[9]; a flush then discards the presented instruction
    ex_ready_i = 0;
    drive(vecs[0].inst, 32'h200, vecs[0].rd1, vecs[0].rd2);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d ready", k), inst_ready_o, 0);
      step();
      chk($sformatf("bp%0d valid", k), valid_o, 1);
      chk($sformatf("bp%0d wd", k), wd_o, 5'd13);
      chk($sformatf("bp%0d pc", k), pc_o, 32'h124);
    end
    flush_i = 1;
    #1;
    chk("flush ready", inst_ready_o, 1);
    step();
    chk("flush valid", valid_o, 0);
    flush_i = 0; inst_valid_i = 0; ex_ready_i = 1;
    step();
    chk("post_flush valid", valid_o, 0);
    chk("post_flush wd held", wd_o, 5'd13);
    chk("post_flush pc held", pc_o, 32'h124);

    // Hazard stall on r4
    accept_v0();
    drive(hz_inst, 32'h400, 32'h4444, 32'h0);
    set_hazard();
    #1;
    chk("hz ready", inst_ready_o, 0);
    step();
    exp_cnt++;
    chk("hz bubble", valid_o, 0);
    chk("hz cnt", stall_cnt_o, exp_cnt);
`ifdef ID_FWD_EN
    clear_fwd();
    mem_wreg_i = 1; mem_wd_i = 5'd4; mem_wdata_i = 32'hCAFEF00D;
    #1;
    chk("lu ready", inst_ready_o, 1);
    step();
    chk("lu valid", valid_o, 1);
    chk("lu mem fwd", reg1_o, 32'hCAFEF00D);
    // DREG AND reading r2 behind a load to r2
    clear_fwd();
    ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 5'd2;
    drive(dreg(OpAnd, 5, 1, 2), 32'h404, 32'h77, 32'h88);
    #1;
    chk("lu2 ready", inst_ready_o, 0);
    step();
    exp_cnt++;
    chk("lu2 bubble", valid_o, 0);
    chk("lu2 cnt", stall_cnt_o, exp_cnt);
    clear_fwd();
    mem_wreg_i = 1; mem_wd_i = 5'd2; mem_wdata_i = 32'hCAFEF00D;
    #1;
    chk("lu2 ready2", inst_ready_o, 1);
    step();
    chk("lu2 reg1", reg1_o, 32'h77);
    chk("lu2 reg2 fwd", reg2_o, 32'hCAFEF00D);
    // EX beats MEM, MEM alone, and address 0
    ex_wreg_i = 1; ex_wd_i = 5'd1; ex_wdata_i = 32'hAAAA5555;
    mem_wreg_i = 1; mem_wd_i = 5'd1; mem_wdata_i = 32'h11111111;
    drive(sreg(OpOr, 3, 1, 32'h1234), 32'h408, 32'h00FF0000, 32'h0);
    #1;
    step();
    chk("fwd ex prio", reg1_o, 32'hAAAA5555);
    ex_wreg_i = 0;
    #1;
    step();
    chk("fwd mem", reg1_o, 32'h11111111);
    ex_wreg_i = 1; ex_wd_i = 5'd0; mem_wd_i = 5'd0;
    drive(sreg(OpOr, 3, 0, 32'h1234), 32'h40C, 32'h00FF0000, 32'h0);
    #1;
    step();
    chk("fwd addr0", reg1_o, 0);
`else
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("hz%0d ready", k), inst_ready_o, 0);
      step();
      exp_cnt++;
      chk($sformatf("hz%0d valid", k), valid_o, 0);
      chk($sformatf("hz%0d cnt", k), stall_cnt_o, exp_cnt);
    end
    clear_fwd();
    ex_wreg_i = 1; ex_wd_i = 5'd4;
    #1;
    chk("hz ex ready", inst_ready_o, 0);
    step();
    exp_cnt++;
    chk("hz ex cnt", stall_cnt_o, exp_cnt);
    clear_fwd();
    mem_wreg_i = 1; mem_wd_i = 5'd4; mem_wdata_i = 32'hBAD0BAD0;
    ex_wreg_i = 1; ex_wd_i = 5'd1; ex_wdata_i = 32'hBAD1BAD1;
    drive(sreg(OpOr, 3, 5, 32'h10), 32'h400, 32'h4444, 32'h0);
    #1;
    chk("nohz ready", inst_ready_o, 1);
    step();
    chk("nohz rf data", reg1_o, 32'h4444);
    clear_fwd();
    drive(hz_inst, 32'h404, 32'h4444, 32'h0);
    #1;
    chk("hz clear ready", inst_ready_o, 1);
    step();
    chk("hz clear valid", valid_o, 1);
    chk("hz clear rf", reg1_o, 32'h4444);
`endif

    // Flush together with a hazard
    accept_v0();
    drive(hz_inst, 32'h500, 32'h4444, 32'h0);
    set_hazard();
    flush_i = 1;
    #1;
    chk("fh ready", inst_ready_o, 1);
    step();
    chk("fh valid", valid_o, 0);
    chk("fh cnt", stall_cnt_o, exp_cnt);
    flush_i = 0;

    // Reset mid-stall
    accept_v0();
    drive(hz_inst, 32'h600, 32'h4444, 32'h0);
    set_hazard();
    #1;
    step();
    exp_cnt++;
    chk("rs cnt", stall_cnt_o, exp_cnt);
    rst = 1;
    #1;
    chk("rs ready", inst_ready_o, 0);
    step();
    chk("rs cnt clr", stall_cnt_o, 0);
    chk("rs valid", valid_o, 0);
    chk("rs pc", pc_o, 0);
    rst = 0; inst_valid_i = 0; clear_fwd();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
